opstack_call_ctrl: RTL
======================

Name: opstack_call_ctrl

Overview:
- Sequencer for the opcode call stack that feeds the execution datapath.
- Accepts CALL requests, which push an opcode, and RET requests, which pop an opcode and issue it to the datapath. Both use a req/ack handshake.
- Holds the popped opcode valid until the datapath signals completion.
- Owns the LIFO storage and the depth counter, and flags overflow and underflow with sticky errors.

Parameters:
- OP_W, 4, opcode width.
- DEPTH, 8, number of stack entries (>=2).
- CNT_W, 4, depth counter width; must satisfy 2^CNT_W > DEPTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- call_req  in  1  push request; held until call_ack.
- call_op  in  OP_W  opcode to push; stable while call_req=1.
- call_ack  out  1  one-cycle pulse: CALL consumed.
- ret_req  in  1  pop/issue request; held until ret_ack.
- ret_ack  out  1  one-cycle pulse: RET consumed.
- exec_op  out  OP_W  opcode presented to the datapath.
- exec_valid  out  1  exec_op valid; held until exec_done.
- exec_done  in  1  datapath finished the current opcode.
- depth  out  CNT_W  number of occupied entries.
- full  out  1  depth==DEPTH.
- empty  out  1  depth==0.
- overflow_err  out  1  sticky: CALL while full.
- underflow_err  out  1  sticky: RET while empty.
- err_clr  in  1  clears both sticky errors.

Behaviour:
- Reset (asynchronous) values:
  - call_ack=0, ret_ack=0, exec_valid=0, exec_op=0, depth=0.
  - full=0, empty=1, overflow_err=0, underflow_err=0, state=IDLE.
  - Stack RAM contents are not reset (don't care).
- Reset asserted mid-EXEC drops exec_valid immediately; the in-flight opcode is lost.
- FSM states:
  - IDLE: requests are arbitrated.
  - ACK: single cycle; the ack pulse is high; requests are ignored.
  - EXEC: exec_valid=1; waiting for exec_done.
- IDLE, ret_req=1 (RET has priority over a simultaneous call_req):
  - Non-empty: next edge exec_op<=stack[depth-1], depth<=depth-1, exec_valid<=1, ret_ack<=1, state<=EXEC.
  - Empty: underflow_err<=1, ret_ack<=1, no issue, state<=ACK.
- IDLE, call_req=1 and ret_req=0:
  - Not full: stack[depth]<=call_op, depth<=depth+1, call_ack<=1, state<=ACK.
  - Full: no write, depth unchanged, overflow_err<=1, call_ack<=1, state<=ACK.
- ACK -> IDLE unconditionally. The acks are therefore one-cycle pulses, and a requester holding req for one cycle after ack is not re-served.
- EXEC:
  - ret_ack pulses in the first EXEC cycle only.
  - exec_op and exec_valid are stable until exec_done=1 is sampled.
  - Then next edge exec_valid<=0, state<=IDLE.
  - call_req and ret_req wait (no ack) during EXEC.
- exec_done outside EXEC is ignored.
- full and empty are registered, consistent with depth in the same cycle.
- err_clr=1 clears both errors next edge. A new error event in the same cycle wins (flag set).
- Throughput: CALL takes 2 cycles per push. RET takes 1 + datapath latency + 1 cycles.

Optional Feature:
- Macro: OPSTACK_TOP_PEEK_EN.
- With the macro defined:
  - Adds output top_op[OP_W-1:0] = stack[depth-1] when depth>0, else 0, updated combinationally from registered state.
  - Adds input ret_peek: when ret_req=1 and ret_peek=1, the RET issues top_op without decrementing depth (non-destructive issue). Handshake and errors are as for a normal RET.
- Without the macro: neither port exists; every RET pops.

Test Plan:
- Reset, then CALL 0x3, 0x5, 0x9 (each held to ack) -> depth=3, call_ack 3 pulses. Then 3x RET with exec_done 2 cycles after exec_valid -> exec_op 0x9, 0x5, 0x3 in order; empty=1 at end.
- Push 8 opcodes (DEPTH=8) -> full=1. 9th CALL 0xF -> call_ack pulses, depth stays 8, overflow_err=1. RET -> exec_op = 8th pushed value, not 0xF.
- RET on empty -> ret_ack pulses, exec_valid stays 0, underflow_err=1. err_clr pulse -> 0. err_clr together with RET on empty -> underflow_err stays 1.
- With depth=2, assert call_req (0xA) and ret_req together -> RET served first (ret_ack, top issued, depth=1). call_ack only after exec_done plus IDLE; final depth=2 with 0xA on top.
- Assert reset while exec_valid=1 and depth=4 -> exec_valid=0 the same cycle (asynchronous), depth=0, empty=1. exec_done after release is ignored.
- OPSTACK_TOP_PEEK_EN: push 0x2, 0x7; RET with ret_peek=1 -> exec_op=0x7, depth stays 2, top_op=0x7.

Source files
------------

// File: rtl/opstack_call_ctrl.sv
// Opcode call-stack sequencer: CALL pushes, RET pops and issues to the datapath.
// Optional macro OPSTACK_TOP_PEEK_EN adds top_op output and ret_peek (non-destructive RET).
module opstack_call_ctrl #(
   parameter int unsigned OP_W  = 4,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             call_req,
   input  logic [OP_W-1:0]  call_op,
   output logic             call_ack,
   input  logic             ret_req,
   output logic             ret_ack,
   output logic [OP_W-1:0]  exec_op,
   output logic             exec_valid,
   input  logic             exec_done,
   output logic [CNT_W-1:0] depth,
   output logic             full,
   output logic             empty,
   output logic             overflow_err,
   output logic             underflow_err,
`ifdef OPSTACK_TOP_PEEK_EN
   output logic [OP_W-1:0]  top_op,
   input  logic             ret_peek,
`endif
   input  logic             err_clr
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACK  = 2'd1;
   localparam logic [1:0] S_EXEC = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [CNT_W-1:0] depth_q, depth_d;
   logic            full_q, full_d;
   logic            empty_q, empty_d;
   logic [OP_W-1:0] exec_op_q, exec_op_d;
   logic            exec_valid_q, exec_valid_d;
   logic            call_ack_q, call_ack_d;
   logic            ret_ack_q, ret_ack_d;
   logic            ovf_q, ovf_d;
   logic            unf_q, unf_d;
   logic            ovf_set_c, unf_set_c;
   logic            push_c;
   logic            peek_c;
   logic [OP_W-1:0] top_c;

   logic [OP_W-1:0] stack_q [DEPTH];

`ifdef OPSTACK_TOP_PEEK_EN
   assign peek_c = ret_peek;
   assign top_op = top_c;
`else
   assign peek_c = 1'b0;
`endif

   // Top-of-stack view; zero when empty
   always_comb begin
      top_c = '0;
      if (depth_q != '0) begin
         top_c = stack_q[AW'(depth_q - CNT_W'(1))];
      end
   end

   // Storage is deliberately left unreset
   always_ff @(posedge clock) begin
      if (push_c) begin
         stack_q[AW'(depth_q)] <= call_op;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         depth_q      <= '0;
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
         exec_op_q    <= '0;
         exec_valid_q <= 1'b0;
         call_ack_q   <= 1'b0;
         ret_ack_q    <= 1'b0;
         ovf_q        <= 1'b0;
         unf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         depth_q      <= depth_d;
         full_q       <= full_d;
         empty_q      <= empty_d;
         exec_op_q    <= exec_op_d;
         exec_valid_q <= exec_valid_d;
         call_ack_q   <= call_ack_d;
         ret_ack_q    <= ret_ack_d;
         ovf_q        <= ovf_d;
         unf_q        <= unf_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      depth_d      = depth_q;
      exec_op_d    = exec_op_q;
      exec_valid_d = exec_valid_q;
      call_ack_d   = 1'b0;
      ret_ack_d    = 1'b0;
      ovf_set_c    = 1'b0;
      unf_set_c    = 1'b0;
      push_c       = 1'b0;

      case (state_q)
         S_IDLE: begin
            // RET wins over a simultaneous CALL
            if (ret_req) begin
               ret_ack_d = 1'b1;
               if (!empty_q) begin
                  exec_op_d    = top_c;
                  exec_valid_d = 1'b1;
                  state_d      = S_EXEC;
                  if (!peek_c) begin
                     depth_d = depth_q - CNT_W'(1);
                  end
               end else begin
                  unf_set_c = 1'b1;
                  state_d   = S_ACK;
               end
            end else if (call_req) begin
               call_ack_d = 1'b1;
               state_d    = S_ACK;
               if (!full_q) begin
                  push_c  = 1'b1;
                  depth_d = depth_q + CNT_W'(1);
               end else begin
                  ovf_set_c = 1'b1;
               end
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         S_EXEC: begin
            if (exec_done) begin
               exec_valid_d = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      full_d  = (depth_d == CNT_W'(DEPTH));
      empty_d = (depth_d == '0);
      ovf_d   = ovf_set_c | (ovf_q & ~err_clr);
      unf_d   = unf_set_c | (unf_q & ~err_clr);
   end

   assign call_ack      = call_ack_q;
   assign ret_ack       = ret_ack_q;
   assign exec_op       = exec_op_q;
   assign exec_valid    = exec_valid_q;
   assign depth         = depth_q;
   assign full          = full_q;
   assign empty         = empty_q;
   assign overflow_err  = ovf_q;
   assign underflow_err = unf_q;

endmodule
